// File: rtl/mem_request_arbiter.sv
// Round-robin arbiter sharing one memory-map controller command port
// between NUM_REQ requesters, with a read-response timeout watchdog.
module mem_request_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exit,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_wen,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    resp_valid,
    output logic                  resp_error,
    output logic [31:0]           resp_addr,
    output logic [31:0]           resp_rdata,
    output logic                  mem_cmd_start,
    output logic                  mem_cmd_write,
    input  logic                  mem_cmd_ready,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_rdata_valid,
    output logic                  busy
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RDATA
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] last_q, last_d;
    logic [IDW-1:0] id_q, id_d;
    logic           wen_q, wen_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           found;
    logic [IDW-1:0] win;
    logic           timeout_hit;
    logic           open;
    logic           accept;

    // Rotating-priority search starting just after the last grant.
    always_comb begin
        int idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (state_q == WAIT_RDATA)
                       && !mem_rdata_valid
                       && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    assign open = !reset && !exit && !timeout_hit
                && ((state_q == IDLE)
                 || (state_q == WAIT_RDATA && mem_rdata_valid));

    assign accept = open && found;
    assign busy   = (state_q != IDLE);

    // Next-state, request capture and all command/response outputs.
    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        id_d          = id_q;
        wen_d         = wen_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cnt_d         = cnt_q;
        req_ready     = '0;
        resp_valid    = '0;
        resp_error    = 1'b0;
        resp_addr     = '0;
        resp_rdata    = '0;
        mem_cmd_start = 1'b0;
        mem_cmd_write = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;

        if (accept) begin
            req_ready[win] = 1'b1;
            id_d           = win;
            wen_d          = req_wen[win];
            addr_d         = req_addr[32*int'(win) +: 32];
            wdata_d        = req_wdata[32*int'(win) +: 32];
            last_d         = win;
            state_d        = ISSUE;
        end

        unique case (state_q)
            IDLE: begin
            end
            ISSUE: begin
                mem_cmd_start = 1'b1;
                mem_cmd_write = wen_q;
                mem_addr      = addr_q;
                mem_wdata     = wdata_q;
                if (mem_cmd_ready) begin
                    if (wen_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_RDATA;
                        cnt_d   = '0;
                    end
                end
            end
            WAIT_RDATA: begin
                if (mem_rdata_valid) begin
                    resp_valid[id_q] = 1'b1;
                    resp_rdata       = mem_rdata;
                    resp_addr        = addr_q;
                    if (!accept) begin
                        state_d = IDLE;
                    end
                end else if (timeout_hit) begin
                    resp_valid[id_q] = 1'b1;
                    resp_error       = 1'b1;
                    resp_addr        = addr_q;
                    state_d          = IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and saved-request registers; reset parks the pointer at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= IDW'(NUM_REQ - 1);
            id_q    <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: reads, round-robin, writes,
// backpressure, timeout, exit and mid-command reset.
module tb_mem_request_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          reset;
    logic          exit;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_wen;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic          resp_error;
    logic [31:0]   resp_addr;
    logic [31:0]   resp_rdata;
    logic          mem_cmd_start;
    logic          mem_cmd_write;
    logic          mem_cmd_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_rdata_valid;
    logic          busy;

    int compared;
    int mismatched;

    mem_request_arbiter #(
        .NUM_REQ(N),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .exit(exit),
        .req_valid(req_valid),
        .req_wen(req_wen),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .resp_valid(resp_valid),
        .resp_error(resp_error),
        .resp_addr(resp_addr),
        .resp_rdata(resp_rdata),
        .mem_cmd_start(mem_cmd_start),
        .mem_cmd_write(mem_cmd_write),
        .mem_cmd_ready(mem_cmd_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] d);
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = d;
    endtask

    initial begin
        int order [6];
        compared        = 0;
        mismatched      = 0;
        reset           = 1'b1;
        exit            = 1'b0;
        req_valid       = '0;
        req_wen         = '0;
        req_addr        = '0;
        req_wdata       = '0;
        mem_cmd_ready   = 1'b1;
        mem_rdata       = '0;
        mem_rdata_valid = 1'b0;
        order           = '{1, 2, 0, 1, 2, 0};

        // Reset state, even with requests pending
        repeat (2) tick();
        req_valid = 3'b111;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(mem_cmd_start), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_resp", 32'(resp_valid), 0);
        req_valid = '0;

        // 1: single read
        reset = 1'b0;
        req_valid = 3'b001;
        set_req(0, 32'h100, 0);
        #1;
        chk("t1_ready", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;
        #1;
        chk("t1_start", 32'(mem_cmd_start), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_wr", 32'(mem_cmd_write), 0);
        chk("t1_ready_iss", 32'(req_ready), 0);
        tick();
        chk("t1_wait_resp", 32'(resp_valid), 0);
        chk("t1_busy", 32'(busy), 1);
        tick();
        tick();
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("t1_resp", 32'(resp_valid), 32'b001);
        chk("t1_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("t1_raddr", resp_addr, 32'h100);
        chk("t1_err", 32'(resp_error), 0);
        tick();
        mem_rdata_valid = 1'b0;
        #1;
        chk("t1_idle", 32'(busy), 0);

        // 2: round-robin, pointer currently at 0
        for (int i = 0; i < N; i++) set_req(i, 32'h1000 + 32'(i) * 32'h10, 0);
        req_valid = 3'b111;
        #1;
        chk("t2_first", 32'(req_ready), 32'b010);
        tick();
        for (int j = 0; j < 6; j++) begin
            chk("t2_start", 32'(mem_cmd_start), 1);
            chk("t2_addr", mem_addr, 32'h1000 + 32'(order[j]) * 32'h10);
            tick();
            mem_rdata_valid = 1'b1;
            mem_rdata = 32'hA0 + 32'(order[j]);
            if (j == 5) req_valid = '0;
            #1;
            chk("t2_resp", 32'(resp_valid), 32'(1) << order[j]);
            chk("t2_rdata", resp_rdata, 32'hA0 + 32'(order[j]));
            if (j < 5)
                chk("t2_next", 32'(req_ready), 32'(1) << order[j+1]);
            else
                chk("t2_last", 32'(req_ready), 0);
            tick();
            mem_rdata_valid = 1'b0;
        end
        #1;
        chk("t2_idle", 32'(busy), 0);

        // 3: write by 1, then read by 0, then 2 takes the rdata cycle
        req_valid = 3'b010;
        req_wen = 3'b010;
        set_req(1, 32'h200, 32'h55);
        #1;
        chk("t3_wready", 32'(req_ready), 32'b010);
        tick();
        req_wen = '0;
        req_valid = 3'b001;
        set_req(0, 32'h300, 0);
        #1;
        chk("t3_wr", 32'(mem_cmd_write), 1);
        chk("t3_waddr", mem_addr, 32'h200);
        chk("t3_wdata", mem_wdata, 32'h55);
        chk("t3_wready_iss", 32'(req_ready), 0);
        tick();
        chk("t3_noresp", 32'(resp_valid), 0);
        chk("t3_rready", 32'(req_ready), 32'b001);
        tick();
        req_valid = 3'b100;
        set_req(2, 32'h400, 32'h77);
        #1;
        chk("t3_raddr", mem_addr, 32'h300);
        chk("t3_rwr", 32'(mem_cmd_write), 0);
        tick();
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'h1234;
        #1;
        chk("t3_resp", 32'(resp_valid), 32'b001);
        chk("t3_b2b", 32'(req_ready), 32'b100);
        tick();
        mem_rdata_valid = 1'b0;
        req_valid = '0;

        // 4: backpressure in ISSUE
        mem_cmd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_req(2, 32'h9000 + 32'(k), 32'hF0 + 32'(k));
            req_valid = 3'b011;
            #1;
            chk("t4_addr", mem_addr, 32'h400);
            chk("t4_wdata", mem_wdata, 32'h77);
            chk("t4_ready", 32'(req_ready), 0);
            chk("t4_start", 32'(mem_cmd_start), 1);
            tick();
        end
        req_valid = '0;
        mem_cmd_ready = 1'b1;
        tick();

        // 5: timeout after 8 WAIT_RDATA cycles
        mem_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 7; c++) begin
            chk("t5_quiet", 32'(resp_valid), 0);
            tick();
        end
        req_valid = 3'b001;
        #1;
        chk("t5_resp", 32'(resp_valid), 32'b100);
        chk("t5_err", 32'(resp_error), 1);
        chk("t5_rdata", resp_rdata, 0);
        chk("t5_addr", resp_addr, 32'h400);
        chk("t5_noacc", 32'(req_ready), 0);
        req_valid = '0;
        tick();
        mem_rdata_valid = 1'b1;
        #1;
        chk("t5_stale", 32'(resp_valid), 0);
        chk("t5_idle", 32'(busy), 0);
        tick();
        mem_rdata_valid = 1'b0;

        // 6a: exit during WAIT_RDATA
        req_valid = 3'b010;
        set_req(1, 32'h500, 0);
        #1;
        chk("t6_ready", 32'(req_ready), 32'b010);
        tick();
        req_valid = '0;
        tick();
        exit = 1'b1;
        req_valid = 3'b101;
        tick();
        mem_rdata_valid = 1'b1;
        mem_rdata = 32'hCAFE;
        #1;
        chk("t6_resp", 32'(resp_valid), 32'b010);
        chk("t6_rdata", resp_rdata, 32'hCAFE);
        chk("t6_noacc", 32'(req_ready), 0);
        tick();
        mem_rdata_valid = 1'b0;
        #1;
        chk("t6_park_rdy", 32'(req_ready), 0);
        chk("t6_park_busy", 32'(busy), 0);
        tick();
        chk("t6_park2", 32'(busy), 0);

        // 6b: reset while in ISSUE
        exit = 1'b0;
        req_valid = 3'b100;
        #1;
        chk("t6_r_ready", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        mem_cmd_ready = 1'b0;
        #1;
        chk("t6_r_start", 32'(mem_cmd_start), 1);
        reset = 1'b1;
        #1;
        chk("t6_r_busy", 32'(busy), 0);
        chk("t6_r_nostart", 32'(mem_cmd_start), 0);
        chk("t6_r_addr", mem_addr, 0);
        tick();
        reset = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("t6_r_first", 32'(req_ready), 32'b001);
        tick();
        req_valid = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
